lift_col_seq: RTL and testbench

//  Parametrised successor to the odd/even lifting FSM. Runs one complete LeGall 5/3

---
 rtl/lift_col_seq_if.sv | 31 +++
 rtl/lift_col_seq.sv | 205 ++++++++++++++++++++
 tb/tb_lift_col_seq.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/lift_col_seq_if.sv
// Column-lifting bus: scheduler control/status plus the sample-RAM port.
// The sequencer is the slave; the scheduler/RAM side is the master.
interface lift_col_seq_if #(
  parameter int DW = 9,
  parameter int AW = 8
);
  logic          start;
  logic          inverse;
  logic [AW-1:0] base_addr;
  logic [AW:0]   col_len;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          done;
  logic          err_len;
  logic          sat;
  logic          pass_o;
  logic [2:0]    state_o;

  modport slave (
    input  start, inverse, base_addr, col_len, mem_rdata,
    output mem_addr, mem_we, mem_wdata, busy, done, err_len, sat, pass_o, state_o
  );

  modport master (
    output start, inverse, base_addr, col_len, mem_rdata,
    input  mem_addr, mem_we, mem_wdata, busy, done, err_len, sat, pass_o, state_o
  );
endinterface

// File: rtl/lift_col_seq.sv
// In-place LeGall 5/3 lifting of one column held in an external sample RAM.
// Forward: predict (odd) then update (even); inverse: un-update then un-predict.
module lift_col_seq #(
  parameter int DW = 9,
  parameter int AW = 8
) (
  input logic           clk,
  input logic           rst_fsm,
  lift_col_seq_if.slave bus
);
  localparam int EW = DW + 3;
  localparam logic [AW:0]          IDX_ZERO   = {(AW+1){1'b0}};
  localparam logic [AW:0]          IDX_ONE    = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]          IDX_TWO    = {{(AW-1){1'b0}}, 2'b10};
  localparam logic [AW-1:0]        ADDR_ZERO  = {AW{1'b0}};
  localparam logic [DW-1:0]        DATA_ZERO  = {DW{1'b0}};
  localparam logic signed [EW-1:0] SAMPLE_MAX = {{(EW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [EW-1:0] SAMPLE_MIN = {{(EW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [EW-1:0] ROUND_TWO  = {{(EW-2){1'b0}}, 2'b10};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_L = 3'd1,
    RD_S = 3'd2,
    RD_R = 3'd3,
    CALC = 3'd4,
    WR   = 3'd5,
    DONE = 3'd6
  } state_t;

  state_t        state_r;
  logic          inv_r;
  logic [AW-1:0] base_r;
  logic [AW:0]   len_r;
  logic [AW:0]   idx_r;
  logic          pass_r;
  logic          second_r;
  logic [DW-1:0] l_r;
  logic [DW-1:0] s_r;
  logic [AW-1:0] mem_addr_r;
  logic          mem_we_r;
  logic [DW-1:0] mem_wdata_r;
  logic          busy_r;
  logic          done_r;
  logic          err_r;
  logic          sat_r;

  logic [AW:0]          idx_rn_s;
  logic                 last_s;
  logic                 sub_s;
  logic signed [EW-1:0] l_x_s;
  logic signed [EW-1:0] s_x_s;
  logic signed [EW-1:0] r_x_s;
  logic signed [EW-1:0] sum_s;
  logic signed [EW-1:0] delta_s;
  logic signed [EW-1:0] res_s;

  function automatic logic out_of_range(input logic signed [EW-1:0] v);
    return (v > SAMPLE_MAX) || (v < SAMPLE_MIN);
  endfunction

  function automatic logic [DW-1:0] clamp_sample(input logic signed [EW-1:0] v);
    logic [DW-1:0] c;
    if (v > SAMPLE_MAX) begin
      c = SAMPLE_MAX[DW-1:0];
    end else if (v < SAMPLE_MIN) begin
      c = SAMPLE_MIN[DW-1:0];
    end else begin
      c = v[DW-1:0];
    end
    return c;
  endfunction

  function automatic logic [AW-1:0] addr_of(input logic [AW-1:0] base, input logic [AW:0] idx);
    return base + idx[AW-1:0];
  endfunction

  // Right neighbour (mirrored at the column end) and end-of-pass detection.
  always_comb begin
    idx_rn_s = (idx_r == len_r - IDX_ONE) ? (len_r - IDX_TWO) : (idx_r + IDX_ONE);
    last_s   = (idx_r + IDX_TWO) >= len_r;
  end

  // Lifting step: odd pass uses (l+r)>>1, even pass (l+r+2)>>2; sign picked by mode.
  always_comb begin
    l_x_s   = {{(EW-DW){l_r[DW-1]}}, l_r};
    s_x_s   = {{(EW-DW){s_r[DW-1]}}, s_r};
    r_x_s   = {{(EW-DW){bus.mem_rdata[DW-1]}}, bus.mem_rdata};
    sum_s   = l_x_s + r_x_s;
    delta_s = pass_r ? ((sum_s + ROUND_TWO) >>> 2'd2) : (sum_s >>> 2'd1);
    sub_s   = (inv_r == pass_r);
    res_s   = sub_s ? (s_x_s - delta_s) : (s_x_s + delta_s);
  end

  // Sequencer: every output is registered and set up for the state being entered.
  always_ff @(posedge clk) begin
    if (rst_fsm) begin
      state_r     <= IDLE;
      inv_r       <= 1'b0;
      base_r      <= ADDR_ZERO;
      len_r       <= IDX_ZERO;
      idx_r       <= IDX_ZERO;
      pass_r      <= 1'b0;
      second_r    <= 1'b0;
      l_r         <= DATA_ZERO;
      s_r         <= DATA_ZERO;
      mem_addr_r  <= ADDR_ZERO;
      mem_we_r    <= 1'b0;
      mem_wdata_r <= DATA_ZERO;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      sat_r       <= 1'b0;
    end else begin
      mem_we_r <= 1'b0;
      done_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          mem_addr_r <= ADDR_ZERO;
          if (bus.start) begin
            inv_r    <= bus.inverse;
            base_r   <= bus.base_addr;
            len_r    <= bus.col_len;
            sat_r    <= 1'b0;
            second_r <= 1'b0;
            busy_r   <= 1'b1;
            if ((bus.col_len < IDX_TWO) || bus.col_len[0]) begin
              err_r   <= 1'b1;
              done_r  <= 1'b1;
              state_r <= DONE;
            end else begin
              // Forward opens on odd index 1 (left = 0); inverse on even 0 (left mirrors to 1).
              err_r      <= 1'b0;
              pass_r     <= bus.inverse;
              idx_r      <= bus.inverse ? IDX_ZERO : IDX_ONE;
              mem_addr_r <= bus.base_addr + {{(AW-1){1'b0}}, bus.inverse};
              state_r    <= RD_L;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RD_L: begin
          mem_addr_r <= addr_of(base_r, idx_r);
          state_r    <= RD_S;
        end
        RD_S: begin
          l_r        <= bus.mem_rdata;
          mem_addr_r <= addr_of(base_r, idx_rn_s);
          state_r    <= RD_R;
        end
        RD_R: begin
          s_r        <= bus.mem_rdata;
          mem_addr_r <= addr_of(base_r, idx_r);
          state_r    <= CALC;
        end
        CALC: begin
          mem_wdata_r <= clamp_sample(res_s);
          sat_r       <= sat_r | out_of_range(res_s);
          mem_we_r    <= 1'b1;
          mem_addr_r  <= addr_of(base_r, idx_r);
          state_r     <= WR;
        end
        WR: begin
          if (last_s && second_r) begin
            mem_addr_r <= ADDR_ZERO;
            done_r     <= 1'b1;
            state_r    <= DONE;
          end else if (last_s) begin
            // Other parity starts at index pass_r; its left neighbour is index ~pass_r.
            second_r   <= 1'b1;
            pass_r     <= ~pass_r;
            idx_r      <= {{AW{1'b0}}, pass_r};
            mem_addr_r <= base_r + {{(AW-1){1'b0}}, ~pass_r};
            state_r    <= RD_L;
          end else begin
            idx_r      <= idx_r + IDX_TWO;
            mem_addr_r <= addr_of(base_r, idx_r + IDX_ONE);
            state_r    <= RD_L;
          end
        end
        DONE: begin
          busy_r     <= 1'b0;
          mem_addr_r <= ADDR_ZERO;
          state_r    <= IDLE;
        end
        default: begin
          busy_r     <= 1'b0;
          mem_addr_r <= ADDR_ZERO;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.err_len   = err_r;
  assign bus.sat       = sat_r;
  assign bus.pass_o    = pass_r;
  assign bus.state_o   = state_r;
endmodule

// File: tb/tb_lift_col_seq.sv
// Self-checking bench for lift_col_seq: vector table, a write scoreboard fed by
// an integer reference model, and hand sequences for reset and round trip.
module tb_lift_col_seq;
  localparam int DW = 9;
  localparam int AW = 8;
  localparam int NV = 8;

  typedef struct {
    logic          inv;
    logic [AW-1:0] base;
    logic [AW:0]   len;
    int            init[8];
    int            expv[8];
    logic          exp_sat;
    logic          exp_err;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    int            data;
    logic          pass;
  } wr_t;

  logic clk = 1'b0;
  logic rst_fsm;
  always #5 clk = ~clk;

  lift_col_seq_if #(.DW(DW), .AW(AW)) bus ();
  lift_col_seq #(.DW(DW), .AW(AW)) dut (.clk(clk), .rst_fsm(rst_fsm), .bus(bus));

  // Sample RAM: one-cycle read latency, bench preload port takes priority.
  logic signed [DW-1:0] ram [0:255];
  logic                 ld_we;
  logic [AW-1:0]        ld_addr;
  logic signed [DW-1:0] ld_data;
  always @(posedge clk) begin
    if (ld_we) ram[ld_addr] <= ld_data;
    else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  int  total  = 0;
  int  passed = 0;
  wr_t exp_q[$];
  vec_t vec[NV];

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act == expv) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  function automatic int fdiv(input int a, input int d);
    if (a >= 0) return a / d;
    else return -((-a + d - 1) / d);
  endfunction

  task automatic preload(input logic [AW-1:0] a, input int d);
    @(negedge clk);
    ld_we = 1'b1; ld_addr = a; ld_data = DW'(d);
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  // Reference: plain integer lifting on a copy of the RAM, queueing each write.
  task automatic model_column(input logic inv, input logic [AW-1:0] base, input int len,
                              output logic msat);
    int m[256];
    int l, r, d, v;
    logic odd;
    logic [AW-1:0] a;
    msat = 1'b0;
    for (int k = 0; k < len; k++) begin
      a = base + AW'(k);
      m[k] = ram[a];
    end
    for (int ps = 0; ps < 2; ps++) begin
      odd = (ps == 0) ? !inv : inv;
      for (int i = (odd ? 1 : 0); i < len; i += 2) begin
        l = (i == 0) ? 1 : i - 1;
        r = (i == len - 1) ? len - 2 : i + 1;
        d = odd ? fdiv(m[l] + m[r], 2) : fdiv(m[l] + m[r] + 2, 4);
        v = (odd != inv) ? m[i] - d : m[i] + d;
        if (v > 255) begin v = 255; msat = 1'b1; end
        if (v < -256) begin v = -256; msat = 1'b1; end
        m[i] = v;
        a = base + AW'(i);
        exp_q.push_back('{addr: a, data: v, pass: !odd});
      end
    end
  endtask

  task automatic run_column(input string tag, input logic inv, input logic [AW-1:0] base,
                            input logic [AW:0] len, input logic exp_err, input logic poke);
    logic msat, busy_ok, we_ok;
    int   c, done_c, writes, budget;
    wr_t  w;
    msat = 1'b0;
    exp_q.delete();
    if (!exp_err) model_column(inv, base, int'(len), msat);
    @(negedge clk);
    bus.start = 1'b1; bus.inverse = inv; bus.base_addr = base; bus.col_len = len;
    @(negedge clk);
    bus.start = 1'b0; bus.inverse = ~inv; bus.base_addr = base ^ 8'h55; bus.col_len = 9'd6;
    c = 1; done_c = -1; writes = 0; busy_ok = 1'b1; we_ok = 1'b1;
    budget = 5 * int'(len) + 20;
    while (c <= budget && done_c < 0) begin
      bus.start = (poke && c == 3);
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.mem_we === 1'b1) begin
        writes++;
        if (bus.state_o !== 3'd5) we_ok = 1'b0;
        if (exp_q.size() == 0) begin
          check({tag, " unexpected_write"}, 1, 0);
        end else begin
          w = exp_q.pop_front();
          check({tag, " wr_addr"}, int'(bus.mem_addr), int'(w.addr));
          check({tag, " wr_data"}, int'($signed(bus.mem_wdata)), w.data);
          check({tag, " wr_pass"}, int'(bus.pass_o), int'(w.pass));
        end
      end
      if (bus.done === 1'b1) begin
        done_c = c;
        check({tag, " err_len"}, int'(bus.err_len), int'(exp_err));
        check({tag, " sat"}, int'(bus.sat), int'(msat));
      end
      c++;
      if (done_c < 0) @(negedge clk);
    end
    bus.start = 1'b0;
    check({tag, " done_cycle"}, done_c, exp_err ? 1 : 5 * int'(len) + 1);
    check({tag, " busy_held"}, int'(busy_ok), 1);
    check({tag, " we_only_in_wr"}, int'(we_ok), 1);
    check({tag, " write_count"}, writes, exp_err ? 0 : int'(len));
    check({tag, " writes_left"}, exp_q.size(), 0);
    @(negedge clk);
    check({tag, " idle_state"}, int'(bus.state_o), 0);
    check({tag, " idle_busy"}, int'(bus.busy), 0);
    check({tag, " idle_addr"}, int'(bus.mem_addr), 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int orig[8];
    logic [AW-1:0] a;

    vec[0] = '{inv: 1'b0, base: 8'h10, len: 9'd4, init: '{10, 20, 30, 40, 0, 0, 0, 0},
               expv: '{10, 0, 33, 10, 0, 0, 0, 0}, exp_sat: 1'b0, exp_err: 1'b0};
    vec[1] = '{inv: 1'b1, base: 8'h10, len: 9'd4, init: '{10, 0, 33, 10, 0, 0, 0, 0},
               expv: '{10, 20, 30, 40, 0, 0, 0, 0}, exp_sat: 1'b0, exp_err: 1'b0};
    vec[2] = '{inv: 1'b0, base: 8'h20, len: 9'd4, init: '{255, -256, 255, -256, 0, 0, 0, 0},
               expv: '{127, -256, 127, -256, 0, 0, 0, 0}, exp_sat: 1'b1, exp_err: 1'b0};
    vec[3] = '{inv: 1'b0, base: 8'hFE, len: 9'd4, init: '{10, 20, 30, 40, 0, 0, 0, 0},
               expv: '{10, 0, 33, 10, 0, 0, 0, 0}, exp_sat: 1'b0, exp_err: 1'b0};
    vec[4] = '{inv: 1'b0, base: 8'h40, len: 9'd2, init: '{5, -7, 0, 0, 0, 0, 0, 0},
               expv: '{-1, -12, 0, 0, 0, 0, 0, 0}, exp_sat: 1'b0, exp_err: 1'b0};
    vec[5] = '{inv: 1'b0, base: 8'h50, len: 9'd3, init: '{1, 2, 3, 4, 0, 0, 0, 0},
               expv: '{1, 2, 3, 4, 0, 0, 0, 0}, exp_sat: 1'b0, exp_err: 1'b1};
    vec[6] = '{inv: 1'b0, base: 8'h50, len: 9'd0, init: '{1, 2, 3, 4, 0, 0, 0, 0},
               expv: '{1, 2, 3, 4, 0, 0, 0, 0}, exp_sat: 1'b0, exp_err: 1'b1};
    vec[7] = '{inv: 1'b1, base: 8'h50, len: 9'd1, init: '{1, 2, 3, 4, 0, 0, 0, 0},
               expv: '{1, 2, 3, 4, 0, 0, 0, 0}, exp_sat: 1'b0, exp_err: 1'b1};

    rst_fsm = 1'b1; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    bus.start = 1'b0; bus.inverse = 1'b0; bus.base_addr = '0; bus.col_len = '0;
    repeat (2) @(negedge clk);
    check("reset state_o", int'(bus.state_o), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset done", int'(bus.done), 0);
    check("reset err_len", int'(bus.err_len), 0);
    check("reset sat", int'(bus.sat), 0);
    check("reset mem_we", int'(bus.mem_we), 0);
    check("reset mem_addr", int'(bus.mem_addr), 0);
    check("reset pass_o", int'(bus.pass_o), 0);
    rst_fsm = 1'b0;

    for (int t = 0; t < NV; t++) begin
      n = vec[t].exp_err ? 4 : int'(vec[t].len);
      for (int k = 0; k < n; k++) preload(vec[t].base + AW'(k), vec[t].init[k]);
      run_column($sformatf("vec%0d", t), vec[t].inv, vec[t].base, vec[t].len,
                 vec[t].exp_err, 1'b0);
      for (int k = 0; k < n; k++) begin
        a = vec[t].base + AW'(k);
        check($sformatf("vec%0d ram[%0d]", t, k), int'(ram[a]), vec[t].expv[k]);
      end
      check($sformatf("vec%0d sticky_sat", t), int'(bus.sat), int'(vec[t].exp_sat));
      check($sformatf("vec%0d sticky_err", t), int'(bus.err_len), int'(vec[t].exp_err));
    end

    // Reset in the middle of the odd pass, then a clean restart on the partial column.
    for (int k = 0; k < 4; k++) preload(8'h30 + AW'(k), 10 * (k + 1));
    @(negedge clk);
    bus.start = 1'b1; bus.inverse = 1'b0; bus.base_addr = 8'h30; bus.col_len = 9'd4;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    rst_fsm = 1'b1;
    @(negedge clk);
    check("midrst state_o", int'(bus.state_o), 0);
    check("midrst busy", int'(bus.busy), 0);
    check("midrst mem_addr", int'(bus.mem_addr), 0);
    check("midrst mem_wdata", int'(bus.mem_wdata), 0);
    check("midrst mem_we", int'(bus.mem_we), 0);
    check("midrst done", int'(bus.done), 0);
    check("midrst ram1", int'(ram[8'h31]), 0);
    check("midrst ram3", int'(ram[8'h33]), 40);
    rst_fsm = 1'b0;
    run_column("after_rst", 1'b0, 8'h30, 9'd4, 1'b0, 1'b1);

    // Forward then inverse on a random unsaturated column must restore it.
    for (int k = 0; k < 8; k++) begin
      orig[k] = int'($urandom_range(0, 120)) - 60;
      preload(8'h80 + AW'(k), orig[k]);
    end
    run_column("rt_fwd", 1'b0, 8'h80, 9'd8, 1'b0, 1'b1);
    run_column("rt_inv", 1'b1, 8'h80, 9'd8, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      a = 8'h80 + AW'(k);
      check($sformatf("roundtrip ram[%0d]", k), int'(ram[a]), orig[k]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
